clock_period_meter: RTL

- Measures a slow, free-running square-wave input against the 50 MHz board clock, e.g. the 1 Hz output of the clock divider.
- Reports period, high time and measurement count in input-clock cycles, and flags a stalled input.
- Sits on the receiving end of divided/tick signals to self-check or display divider rates.

---
 rtl/clock_period_meter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in cin cycles,
// with a sticky stall flag when no rising edge arrives within TIMEOUT cycles.
module clock_period_meter #(
   parameter int          CNT_W   = 32,
   parameter int unsigned TIMEOUT = 32'd100000000,
   parameter int          NCNT_W  = 16
) (
   input  logic              cin,
   input  logic              resetn,
   input  logic              sig_in,
   input  logic              clr,
   output logic [CNT_W-1:0]  period,
   output logic [CNT_W-1:0]  high_time,
   output logic              valid,
   output logic              timeout,
   output logic [NCNT_W-1:0] meas_count
);

   localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

   typedef enum logic {
      S_IDLE,
      S_MEASURE
   } state_t;

   logic              r_s1, r_s2, r_s3;
   logic              w_rise, w_fall;

   state_t            r_state, w_state_next;
   logic [CNT_W-1:0]  r_cnt, w_cnt_next;
   logic [CNT_W-1:0]  r_hi_lat, w_hi_lat_next;
   logic [CNT_W-1:0]  r_period, w_period_next;
   logic [CNT_W-1:0]  r_high_time, w_high_time_next;
   logic              r_valid, w_valid_next;
   logic              r_timeout, w_timeout_next;
   logic [NCNT_W-1:0] r_meas_count, w_meas_count_next;

   // Synchronizer and edge register are deliberately untouched by clr.
   always_ff @(posedge cin or negedge resetn) begin
      if (!resetn) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= sig_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_rise = r_s2 & ~r_s3;
   assign w_fall = ~r_s2 & r_s3;

   always_ff @(posedge cin or negedge resetn) begin
      if (!resetn) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_hi_lat     <= '0;
         r_period     <= '0;
         r_high_time  <= '0;
         r_valid      <= 1'b0;
         r_timeout    <= 1'b0;
         r_meas_count <= '0;
      end else begin
         r_state      <= w_state_next;
         r_cnt        <= w_cnt_next;
         r_hi_lat     <= w_hi_lat_next;
         r_period     <= w_period_next;
         r_high_time  <= w_high_time_next;
         r_valid      <= w_valid_next;
         r_timeout    <= w_timeout_next;
         r_meas_count <= w_meas_count_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_cnt_next        = r_cnt;
      w_hi_lat_next     = r_hi_lat;
      w_period_next     = r_period;
      w_high_time_next  = r_high_time;
      w_valid_next      = 1'b0;
      w_timeout_next    = r_timeout;
      w_meas_count_next = r_meas_count;

      if (clr) begin
         // Clear wins over any edge detected this cycle; that edge is dropped.
         w_state_next      = S_IDLE;
         w_cnt_next        = '0;
         w_hi_lat_next     = '0;
         w_period_next     = '0;
         w_high_time_next  = '0;
         w_timeout_next    = 1'b0;
         w_meas_count_next = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_cnt_next = '0;
               if (w_rise) begin
                  w_state_next  = S_MEASURE;
                  w_hi_lat_next = '0;
               end
            end
            S_MEASURE: begin
               w_cnt_next = r_cnt + 1'b1;
               if (w_fall) begin
                  w_hi_lat_next = r_cnt + 1'b1;
               end
               // A rise on the timeout cycle completes the measurement instead.
               if (w_rise) begin
                  w_period_next     = r_cnt + 1'b1;
                  w_high_time_next  = r_hi_lat;
                  w_valid_next      = 1'b1;
                  w_meas_count_next = r_meas_count + 1'b1;
                  w_timeout_next    = 1'b0;
                  w_cnt_next        = '0;
               end else if (r_cnt == TIMEOUT_M1) begin
                  w_timeout_next = 1'b1;
                  w_state_next   = S_IDLE;
                  w_cnt_next     = '0;
               end
            end
            default: begin
               w_state_next = S_IDLE;
               w_cnt_next   = '0;
            end
         endcase
      end
   end

   assign period     = r_period;
   assign high_time  = r_high_time;
   assign valid      = r_valid;
   assign timeout    = r_timeout;
   assign meas_count = r_meas_count;

endmodule
